// File: rtl/ghost_mode_scheduler.sv
// Ghost behaviour-mode and house-release scheduler for the maze game.
// Optional: FRIGHT_PAUSE_RELEASE_EN freezes the release counter while frightened.
module ghost_mode_scheduler #(
   parameter int SCATTER_FRAMES = 210,
   parameter int CHASE_FRAMES   = 600,
   parameter int NUM_CYCLES     = 4,
   parameter int FRIGHT_FRAMES  = 180,
   parameter int FLASH_FRAMES   = 60,
   parameter int RELEASE_GAP    = 90,
   parameter int FREEZE_FRAMES  = 60
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       game_start,
   input  logic       power_pellet,
   input  logic       player_dead,
   output logic [1:0] mode,
   output logic [3:0] ghost_release,
   output logic       reverse,
   output logic       flash,
   output logic [2:0] cycle_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCATTER,
      S_CHASE,
      S_FRIGHT,
      S_FREEZE
   } state_t;

   localparam int MAX_A = (SCATTER_FRAMES > CHASE_FRAMES) ?
                          SCATTER_FRAMES : CHASE_FRAMES;
   localparam int MAX_B = (FRIGHT_FRAMES > FREEZE_FRAMES) ?
                          FRIGHT_FRAMES : FREEZE_FRAMES;
   localparam int MAX_F = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_F + 1);
   localparam int R_MAX = 3 * RELEASE_GAP;
   localparam int RW    = $clog2(R_MAX + 1);

   localparam logic [CW-1:0] SC_N  = CW'(SCATTER_FRAMES);
   localparam logic [CW-1:0] CH_N  = CW'(CHASE_FRAMES);
   localparam logic [CW-1:0] FR_N  = CW'(FRIGHT_FRAMES);
   localparam logic [CW-1:0] FL_N  = CW'(FLASH_FRAMES);
   localparam logic [CW-1:0] FZ_N  = CW'(FREEZE_FRAMES);
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [RW-1:0] GAP1  = RW'(RELEASE_GAP);
   localparam logic [RW-1:0] GAP2  = RW'(2 * RELEASE_GAP);
   localparam logic [RW-1:0] GAP3  = RW'(R_MAX);
   localparam logic [2:0]    LAST  = 3'(NUM_CYCLES - 1);

   state_t        state_q, state_d;
   state_t        sav_st_q, sav_st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] sav_cnt_q, sav_cnt_d;
   logic [RW-1:0] rel_q, rel_d;
   logic [2:0]    cyc_q, cyc_d;
   logic [1:0]    mode_q, mode_d;
   logic [3:0]    gr_q, gr_d;
   logic          rev_q, rev_d;
   logic          fl_q, fl_d;
   logic          rel_adv;
   logic          hold;

   always_comb begin
      state_d   = state_q;
      sav_st_d  = sav_st_q;
      cnt_d     = cnt_q;
      sav_cnt_d = sav_cnt_q;
      rel_d     = rel_q;
      cyc_d     = cyc_q;
      rev_d     = 1'b0;
      rel_adv   = (state_q == S_SCATTER) || (state_q == S_CHASE);
`ifdef FRIGHT_PAUSE_RELEASE_EN
      rel_adv   = rel_adv;
`else
      rel_adv   = rel_adv || (state_q == S_FRIGHT);
`endif
      hold      = (state_q == S_CHASE) && (cyc_q == LAST);

      if (startOfFrame && rel_adv && (rel_q != GAP3))
         rel_d = rel_q + 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (game_start) begin
               state_d = S_SCATTER;
               cnt_d   = SC_N;
               cyc_d   = 3'd0;
               rel_d   = '0;
            end
         end
         S_SCATTER, S_CHASE, S_FRIGHT: begin
            if (player_dead) begin
               state_d   = S_FREEZE;
               cnt_d     = FZ_N;
               rel_d     = '0;
               sav_st_d  = S_SCATTER;
               sav_cnt_d = '0;
            end else if (power_pellet) begin
               cnt_d = FR_N;
               if (state_q != S_FRIGHT) begin
                  sav_st_d  = state_q;
                  sav_cnt_d = cnt_q;
                  state_d   = S_FRIGHT;
                  rev_d     = 1'b1;
               end
            end else if (startOfFrame && !hold) begin
               if (cnt_q == ONE) begin
                  unique case (state_q)
                     S_SCATTER: begin
                        state_d = S_CHASE;
                        cnt_d   = CH_N;
                        rev_d   = 1'b1;
                     end
                     S_CHASE: begin
                        state_d = S_SCATTER;
                        cnt_d   = SC_N;
                        cyc_d   = cyc_q + 3'd1;
                        rev_d   = 1'b1;
                     end
                     default: begin
                        state_d = sav_st_q;
                        cnt_d   = sav_cnt_q;
                     end
                  endcase
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_FREEZE: begin
            if (startOfFrame) begin
               if (cnt_q == ONE) begin
                  state_d = S_SCATTER;
                  cnt_d   = SC_N;
                  cyc_d   = 3'd0;
                  rel_d   = '0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      unique case (state_d)
         S_SCATTER: mode_d = 2'd1;
         S_CHASE:   mode_d = 2'd2;
         S_FRIGHT:  mode_d = 2'd3;
         default:   mode_d = 2'd0;
      endcase

      // release bits are sticky until the game (re)starts from the house
      if ((state_d == S_IDLE) || (state_d == S_FREEZE))
         gr_d = 4'b0000;
      else
         gr_d = gr_q | {rel_d >= GAP3, rel_d >= GAP2, rel_d >= GAP1, 1'b1};

      fl_d = (state_d == S_FRIGHT) && (cnt_d <= FL_N);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= S_IDLE;
         sav_st_q  <= S_SCATTER;
         cnt_q     <= '0;
         sav_cnt_q <= '0;
         rel_q     <= '0;
         cyc_q     <= 3'd0;
         mode_q    <= 2'd0;
         gr_q      <= 4'b0000;
         rev_q     <= 1'b0;
         fl_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         sav_st_q  <= sav_st_d;
         cnt_q     <= cnt_d;
         sav_cnt_q <= sav_cnt_d;
         rel_q     <= rel_d;
         cyc_q     <= cyc_d;
         mode_q    <= mode_d;
         gr_q      <= gr_d;
         rev_q     <= rev_d;
         fl_q      <= fl_d;
      end
   end

   assign mode          = mode_q;
   assign ghost_release = gr_q;
   assign reverse       = rev_q;
   assign flash         = fl_q;
   assign cycle_idx     = cyc_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed scoreboard bench for ghost_mode_scheduler, small frame counts.
module tb_ghost_mode_scheduler;

   logic       clk;
   logic       resetN;
   logic       startOfFrame;
   logic       game_start;
   logic       power_pellet;
   logic       player_dead;
   logic [1:0] mode;
   logic [3:0] ghost_release;
   logic       reverse;
   logic       flash;
   logic [2:0] cycle_idx;

   typedef struct packed {
      logic [1:0] m;
      logic [3:0] r;
      logic       rv;
      logic       fl;
      logic [2:0] c;
   } obs_t;

   obs_t expq[$];
   int   checks;
   int   failures;

   ghost_mode_scheduler #(
      .SCATTER_FRAMES(4),
      .CHASE_FRAMES  (6),
      .NUM_CYCLES    (2),
      .FRIGHT_FRAMES (5),
      .FLASH_FRAMES  (2),
      .RELEASE_GAP   (3),
      .FREEZE_FRAMES (2)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .game_start   (game_start),
      .power_pellet (power_pellet),
      .player_dead  (player_dead),
      .mode         (mode),
      .ghost_release(ghost_release),
      .reverse      (reverse),
      .flash        (flash),
      .cycle_idx    (cycle_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(int m, int r, int rv, int fl, int c);
      obs_t o;
      o.m  = 2'(m);
      o.r  = 4'(r);
      o.rv = 1'(rv);
      o.fl = 1'(fl);
      o.c  = 3'(c);
      return o;
   endfunction

   task automatic check(input string tag);
      obs_t e;
      obs_t o;
      e = expq.pop_front();
      o = {mode, ghost_release, reverse, flash, cycle_idx};
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s: got mode=%0d rel=%b rev=%b flash=%b cyc=%0d expected mode=%0d rel=%b rev=%b flash=%b cyc=%0d",
                tag, o.m, o.r, o.rv, o.fl, o.c, e.m, e.r, e.rv, e.fl, e.c);
      end
   endtask

   task automatic step(input logic sof, input logic gs, input logic pp,
                       input logic pd, input obs_t e, input string tag);
      startOfFrame = sof;
      game_start   = gs;
      power_pellet = pp;
      player_dead  = pd;
      expq.push_back(e);
      @(negedge clk);
      startOfFrame = 1'b0;
      game_start   = 1'b0;
      power_pellet = 1'b0;
      player_dead  = 1'b0;
      check(tag);
   endtask

   task automatic frame(input obs_t e, input string tag);
      obs_t q;
      q    = e;
      step(1'b1, 1'b0, 1'b0, 1'b0, e, tag);
      q.rv = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, q, {tag, "_hold"});
   endtask

   initial begin
      int m;
      int r;
      checks       = 0;
      failures     = 0;
      resetN       = 1'b1;
      startOfFrame = 1'b0;
      game_start   = 1'b0;
      power_pellet = 1'b0;
      player_dead  = 1'b0;
      #1 resetN = 1'b0;
      repeat (2) @(negedge clk);
      expq.push_back(mk(0, 0, 0, 0, 0));
      check("reset");
      resetN = 1'b1;
      @(negedge clk);

      step(0, 0, 1, 0, mk(0, 0, 0, 0, 0), "idle_pellet");
      step(0, 0, 0, 1, mk(0, 0, 0, 0, 0), "idle_dead");
      step(0, 1, 0, 0, mk(1, 1, 0, 0, 0), "start");

      for (int f = 1; f <= 30; f++) begin
         m = (f < 4) ? 1 : (f < 10) ? 2 : (f < 14) ? 1 : 2;
         r = (f >= 9) ? 15 : (f >= 6) ? 7 : (f >= 3) ? 3 : 1;
         frame(mk(m, r, (f == 4 || f == 10 || f == 14) ? 1 : 0, 0,
                  (f >= 10) ? 1 : 0), $sformatf("t1_f%0d", f));
      end

      step(0, 0, 1, 1, mk(0, 0, 0, 0, 1), "dead_pellet");
      frame(mk(0, 0, 0, 0, 1), "freeze1");
      frame(mk(1, 1, 0, 0, 0), "freeze_exit");

      frame(mk(1, 1, 0, 0, 0), "s1");
      frame(mk(1, 1, 0, 0, 0), "s2");
      step(0, 0, 1, 0, mk(3, 1, 1, 0, 0), "pellet");
      step(0, 0, 0, 0, mk(3, 1, 0, 0, 0), "pellet_gap");
      frame(mk(3, 3, 0, 0, 0), "fr1");
      frame(mk(3, 3, 0, 0, 0), "fr2");
      frame(mk(3, 3, 0, 1, 0), "fr3");
      frame(mk(3, 7, 0, 1, 0), "fr4");
      frame(mk(1, 7, 0, 0, 0), "fr_exit");
      frame(mk(1, 7, 0, 0, 0), "resume1");
      frame(mk(2, 15, 1, 0, 0), "resume_exp");

      step(0, 0, 1, 0, mk(3, 15, 1, 0, 0), "pellet2");
      step(0, 0, 0, 0, mk(3, 15, 0, 0, 0), "pellet2_gap");
      frame(mk(3, 15, 0, 0, 0), "ex1");
      frame(mk(3, 15, 0, 0, 0), "ex2");
      frame(mk(3, 15, 0, 1, 0), "ex3");
      step(0, 0, 1, 0, mk(3, 15, 0, 0, 0), "repellet");
      frame(mk(3, 15, 0, 0, 0), "ex4");
      frame(mk(3, 15, 0, 0, 0), "ex5");
      frame(mk(3, 15, 0, 1, 0), "ex6");
      frame(mk(3, 15, 0, 1, 0), "ex7");
      frame(mk(2, 15, 0, 0, 0), "ex8");

      for (int f = 1; f <= 5; f++)
         frame(mk(2, 15, 0, 0, 0), $sformatf("ch_f%0d", f));
      step(1, 0, 1, 0, mk(3, 15, 1, 0, 0), "pellet_on_expiry");
      step(0, 0, 0, 0, mk(3, 15, 0, 0, 0), "poe_gap");
      for (int f = 1; f <= 4; f++)
         frame(mk(3, 15, 0, (f >= 3) ? 1 : 0, 0), $sformatf("poe_fr%0d", f));
      frame(mk(2, 15, 0, 0, 0), "poe_restore");
      frame(mk(1, 15, 1, 0, 1), "poe_last_frame");

      step(0, 0, 1, 0, mk(3, 15, 1, 0, 1), "t6_pellet");
      frame(mk(3, 15, 0, 0, 1), "t6_fr1");
      #2 resetN = 1'b0;
      expq.push_back(mk(0, 0, 0, 0, 0));
      #1 check("async_reset");
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      step(0, 0, 1, 0, mk(0, 0, 0, 0, 0), "pellet_after_reset");
      frame(mk(0, 0, 0, 0, 0), "idle_frame");
      step(0, 1, 0, 0, mk(1, 1, 0, 0, 0), "restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
